// File: rtl/roll_buffer_pkg.sv
// Shared roll-mode definitions used by the roll decimator and the roll buffer.
package roll_buffer_pkg;

  // Sample width produced by the roll decimator
  localparam int ROLL_DATA_W = 12;

  // Number of screen columns kept in the rolling trace
  localparam int ROLL_DEPTH  = 640;

  // Column/address width; 2**ROLL_ADDR_W must cover ROLL_DEPTH
  localparam int ROLL_ADDR_W = 10;

endpackage : roll_buffer_pkg

// File: rtl/roll_ram.sv
// Simple dual-port sample store: one write port, one registered read-first read port.
module roll_ram
  import roll_buffer_pkg::*;
#(
  parameter int DATA_W = ROLL_DATA_W,
  parameter int DEPTH  = ROLL_DEPTH,
  parameter int ADDR_W = ROLL_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share the edge; the read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule : roll_ram

// File: rtl/roll_buffer.sv
// Rolling trace buffer: oldest sample at column 0, newest at column DEPTH-1.
module roll_buffer
  import roll_buffer_pkg::*;
#(
  parameter int DATA_W = ROLL_DATA_W,
  parameter int DEPTH  = ROLL_DEPTH,
  parameter int ADDR_W = ROLL_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] value,
  input  logic              w_clk,
  input  logic              freeze,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   fill
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

  logic              w_clk_q;
  logic              wr_edge;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_ptr;

  logic [ADDR_W:0]   col_x;
  logic [ADDR_W:0]   raw_sum;
  logic [ADDR_W:0]   wrapped_sum;
  logic [ADDR_W-1:0] phys_addr;
  logic              col_valid;

  logic [ADDR_W-1:0] rd_addr_q;
  logic              valid_q1;
  logic              valid_q2;
  logic [DATA_W-1:0] ram_rdata;

  // A write happens once per rising strobe; freeze and clear both veto it
  assign wr_edge = w_clk & ~w_clk_q;
  assign wr_en   = wr_edge & ~freeze & ~clear;

  // Strobe history keeps following w_clk even while frozen, so frozen edges are lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_clk_q <= 1'b0;
    end else begin
      w_clk_q <= w_clk;
    end
  end

  // Write pointer wraps at DEPTH; fill saturates at DEPTH while old samples get overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      if ({1'b0, wr_ptr} == LAST_X) begin
        wr_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fill != DEPTH_X) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Column to physical address: wr_ptr points at the oldest sample once the trace is full
  always_comb begin
    col_x       = {1'b0, rd_x};
    raw_sum     = {1'b0, wr_ptr} + col_x;
    wrapped_sum = raw_sum;
    if (raw_sum >= DEPTH_X) begin
      wrapped_sum = raw_sum - DEPTH_X;
    end
    phys_addr = wrapped_sum[ADDR_W-1:0];
    col_valid = (col_x < DEPTH_X) && (col_x >= (DEPTH_X - fill));
  end

  // First read stage captures the mapped address and its validity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      valid_q1  <= 1'b0;
    end else begin
      rd_addr_q <= phys_addr;
      valid_q1  <= col_valid;
    end
  end

  // Second read stage carries validity alongside the RAM output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q2 <= 1'b0;
    end else begin
      valid_q2 <= valid_q1;
    end
  end

  roll_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (value),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  // RAM has no reset, so the output is masked by the reset-clean valid flag
  assign rd_valid = valid_q2;
  assign rd_data  = valid_q2 ? ram_rdata : '0;

endmodule : roll_buffer
